frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter NUM_FACES, 6: faces per frame.
REQ-002 Parameter PIX_PER_FACE, 64: LEDs per face (8x8 matrix).
REQ-003 Parameter LATCH_CYCLES, 2000: low-latch gap in clk cycles (50 us at 40 MHz).
REQ-004 Port clk  in  1  clock; all logic on posedge clk.
REQ-005 Port reset  in  1  reset, synchronous, active-high.
REQ-006 Port orientation  in  432  cube state, 6 faces x 9 squares x 8-bit color code; face f occupies bits [72f+71:72f].
REQ-007 Port start  in  1  single-cycle request to display the current orientation.
REQ-008 Port face_orient  out  72  snapshot slice for the face being sent.
REQ-009 Port face_idx  out  3  face being sent, 0..NUM_FACES-1.
REQ-010 Port pix_idx  out  6  LED index within the face, 0..PIX_PER_FACE-1.
REQ-011 Port pix_valid  out  1  face_orient/face_idx/pix_idx describe a pixel to serialize.
REQ-012 Port pix_ready  in  1  serializer accepts the pixel; a transfer occurs when pix_valid and pix_ready are both high.
REQ-013 Port latching  out  1  high during the latch gap.
REQ-014 Port busy  out  1  high in every state except IDLE.
REQ-015 Port frame_done  out  1  one-cycle pulse on frame completion.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SNAP, SEND, LATCH.
REQ-017 IDLE: when start or pending is high, go to SNAP next cycle; otherwise stay in IDLE.
REQ-018 SNAP: lasts one cycle; registers all 432 bits of orientation into the snapshot; clears face_idx, pix_idx and pending; goes to SEND.
REQ-019 Output face_orient SHALL be a combinational select of the snapshot by face_idx; orientation changes after SNAP SHALL NOT affect the frame.
REQ-020 SEND: pix_valid is high; indices hold while pix_ready is low; on each transfer pix_idx increments.
REQ-021 When pix_idx wraps from PIX_PER_FACE-1 to 0, face_idx increments.
REQ-022 A transfer at face_idx=NUM_FACES-1 with pix_idx=PIX_PER_FACE-1 goes to LATCH and loads the latch counter with 0.
REQ-023 LATCH: latching is high and pix_valid is low; the counter increments each cycle.
REQ-024 In LATCH, at count LATCH_CYCLES-1, frame_done pulses for one cycle and the state returns to IDLE.
REQ-025 A start received while busy SHALL set pending; multiple starts collapse into one pending frame.
REQ-026 A start coinciding with the frame_done cycle SHALL also set pending.
REQ-027 A frame has 384 transfers and lasts at least 1 + 384 + LATCH_CYCLES cycles; pix_ready held high gives exactly that length.
REQ-028 Counters SHALL be sized to their ranges: latch counter of width clog2(LATCH_CYCLES); no arithmetic overflow permitted.
REQ-029 pix_valid SHALL NOT drop in SEND until its transfer completes.

Reset
REQ-030 Reset SHALL force state IDLE and clear pending, face_idx, pix_idx, the latch counter and the snapshot.
REQ-031 During and after reset, pix_valid, latching, busy and frame_done SHALL be 0.
REQ-032 Reset asserted mid-SEND or mid-LATCH SHALL abort the frame without a frame_done pulse.
REQ-033 Reset SHALL take priority over start.

Structure
REQ-034 The state enum, NUM_FACES, PIX_PER_FACE and LATCH_CYCLES defaults SHALL live in a shared package, rubiks_pkg, for reuse by the SPI and serializer blocks.
REQ-035 The latch-gap timer SHALL be one sub-module, gap_timer, with ports load, count-done and a LATCH_CYCLES parameter; all other logic stays in frame_scheduler.

Verification
Benches use LATCH_CYCLES=8.
REQ-036 Basic frame: pix_ready always 1, one start pulse -> 384 transfers, then 8 cycles with latching=1, then frame_done exactly 393 cycles after SNAP.
REQ-037 Backpressure: pix_ready low for 5 cycles at face 2, pixel 63 -> indices hold at (2,63) with pix_valid=1; on release the next transfer is (3,0).
REQ-038 Snapshot integrity: write face 0 = 0x01 per square, start, then change orientation during SEND -> face_orient for face 0 stays 72'h010101010101010101.
REQ-039 Pending: three start pulses during SEND, plus one in the frame_done cycle -> exactly one extra frame, starting 2 cycles after frame_done (IDLE, then SNAP).
REQ-040 Reset mid-LATCH at count 4 -> next cycle busy=0 and latching=0, and no frame_done pulse.
REQ-041 Idle stability: no start for 100 cycles after reset -> pix_valid, busy and frame_done remain 0.

Source files
------------

// File: rtl/rubiks_pkg.sv
// Shared definitions for the cube display pipeline: frame geometry, latch gap
// default and the frame scheduler state encoding.
package rubiks_pkg;

  localparam int NUM_FACES        = 6;
  localparam int PIX_PER_FACE     = 64;
  localparam int LATCH_CYCLES     = 2000;
  localparam int SQUARE_BITS      = 8;
  localparam int SQUARES_PER_FACE = 9;
  localparam int FACE_BITS        = SQUARE_BITS * SQUARES_PER_FACE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } sched_state_e;

endpackage

// File: rtl/gap_timer.sv
// Latch-gap timer: load restarts the count at 0, the count then advances once
// per cycle and parks at LATCH_CYCLES-1, where done is asserted.
module gap_timer #(
  parameter int LATCH_CYCLES = rubiks_pkg::LATCH_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATCH_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: restart on load, otherwise step until the last value and hold there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: snapshots the cube orientation on request, walks every LED
// of every face through a valid/ready handshake, then holds the latch gap.
// Requests arriving while a frame is in flight collapse into one pending frame.
module frame_scheduler
  import rubiks_pkg::*;
#(
  parameter int NUM_FACES    = rubiks_pkg::NUM_FACES,
  parameter int PIX_PER_FACE = rubiks_pkg::PIX_PER_FACE,
  parameter int LATCH_CYCLES = rubiks_pkg::LATCH_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FACES*FACE_BITS-1:0] orientation,
  input  logic                           start,
  output logic [FACE_BITS-1:0]           face_orient,
  output logic [2:0]                     face_idx,
  output logic [5:0]                     pix_idx,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic                           latching,
  output logic                           busy,
  output logic                           frame_done
);

  localparam logic [2:0] FACE_LAST = 3'(NUM_FACES - 1);
  localparam logic [5:0] PIX_LAST  = 6'(PIX_PER_FACE - 1);

  sched_state_e state_q, state_d;
  logic [2:0]   face_idx_q, face_idx_d;
  logic [5:0]   pix_idx_q, pix_idx_d;
  logic         pending_q, pending_d;
  logic         snap_en;
  logic         timer_load;
  logic         timer_done;

  logic [NUM_FACES-1:0][FACE_BITS-1:0] snap_q;

  // One snapshot register per face; captured only in SNAP so later orientation
  // changes never leak into a frame already in progress.
  generate
    for (genvar gi = 0; gi < NUM_FACES; gi++) begin : g_snap
      logic [FACE_BITS-1:0] slice_q;

      // Capture this face's slice of the orientation bus.
      always_ff @(posedge clk) begin
        if (reset) begin
          slice_q <= '0;
        end else if (snap_en) begin
          slice_q <= orientation[gi*FACE_BITS +: FACE_BITS];
        end
      end

      assign snap_q[gi] = slice_q;
    end
  endgenerate

  // Face data follows the current face index straight out of the snapshot.
  always_comb begin
    face_orient = '0;
    if (int'(face_idx_q) < NUM_FACES) begin
      face_orient = snap_q[face_idx_q];
    end
  end

  gap_timer #(
    .LATCH_CYCLES(LATCH_CYCLES)
  ) u_gap_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .done (timer_done)
  );

  // Next-state, index stepping, pending tracking and handshake outputs.
  always_comb begin
    state_d    = state_q;
    face_idx_d = face_idx_q;
    pix_idx_d  = pix_idx_q;
    pending_d  = pending_q;
    snap_en    = 1'b0;
    timer_load = 1'b0;
    pix_valid  = 1'b0;
    latching   = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start || pending_q) begin
          state_d = SNAP;
        end
      end
      SNAP: begin
        snap_en    = 1'b1;
        face_idx_d = '0;
        pix_idx_d  = '0;
        pending_d  = 1'b0;
        state_d    = SEND;
      end
      SEND: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          if (pix_idx_q == PIX_LAST) begin
            pix_idx_d = '0;
            if (face_idx_q == FACE_LAST) begin
              face_idx_d = '0;
              timer_load = 1'b1;
              state_d    = LATCH;
            end else begin
              face_idx_d = face_idx_q + 3'd1;
            end
          end else begin
            pix_idx_d = pix_idx_q + 6'd1;
          end
        end
      end
      LATCH: begin
        latching = 1'b1;
        if (timer_done) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request while busy (including SNAP and the frame_done cycle) is
    // remembered and wins over the SNAP clear.
    if (start && busy) begin
      pending_d = 1'b1;
    end
  end

  // State, index and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      face_idx_q <= '0;
      pix_idx_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      face_idx_q <= face_idx_d;
      pix_idx_q  <= pix_idx_d;
      pending_q  <= pending_d;
    end
  end

  assign face_idx = face_idx_q;
  assign pix_idx  = pix_idx_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler with a short latch gap: a frame-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_frame_scheduler;

  localparam int LC      = 8;
  localparam int NF      = 6;
  localparam int PPF     = 64;
  localparam int NPIX    = NF * PPF;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         pix_ready;
  logic [431:0] orientation;
  logic [71:0]  face_orient;
  logic [2:0]   face_idx;
  logic [5:0]   pix_idx;
  logic         pix_valid;
  logic         latching;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_scheduler #(
    .NUM_FACES   (NF),
    .PIX_PER_FACE(PPF),
    .LATCH_CYCLES(LC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .orientation(orientation),
    .start      (start),
    .face_orient(face_orient),
    .face_idx   (face_idx),
    .pix_idx    (pix_idx),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .latching   (latching),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 snapshot, 2 sending (m_n pixels done),
  // 3 latch gap (m_gap cycles elapsed); pending flag; snapshot copy.
  int           m_phase = 0;
  int           m_n     = 0;
  int           m_gap   = 0;
  bit           m_pend  = 1'b0;
  bit           m_live  = 1'b0;
  bit           m_was_busy;
  logic [431:0] m_snap  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_n     = 0;
      m_gap   = 0;
      m_pend  = 1'b0;
      m_snap  = '0;
    end else begin
      m_was_busy = (m_phase != 0);
      case (m_phase)
        0: if (start || m_pend) m_phase = 1;
        1: begin
          m_snap  = orientation;
          m_pend  = 1'b0;
          m_n     = 0;
          m_phase = 2;
        end
        2: if (pix_ready) begin
          m_n++;
          if (m_n == NPIX) begin
            m_phase = 3;
            m_gap   = 0;
          end
        end
        default: begin
          if (m_gap == LC - 1) m_phase = 0;
          else m_gap++;
        end
      endcase
      if (start && m_was_busy) m_pend = 1'b1;
    end
    m_live = 1'b1;
  end

  // Compare DUT outputs against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", 72'(busy), 72'(m_phase != 0));
      chk("pix_valid", 72'(pix_valid), 72'(m_phase == 2));
      chk("latching", 72'(latching), 72'(m_phase == 3));
      chk("frame_done", 72'(frame_done), 72'(m_phase == 3 && m_gap == LC - 1));
      if (m_phase == 2) begin
        chk("face_idx", 72'(face_idx), 72'(m_n / PPF));
        chk("pix_idx", 72'(pix_idx), 72'(m_n % PPF));
        chk("face_orient", face_orient, m_snap[(m_n / PPF) * 72 +: 72]);
      end
    end
  end

  // Pulse start across exactly one rising edge; returns just after that edge,
  // so the next falling edge lands in the SNAP cycle.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Watch falling edges until frame_done, counting busy cycles, transfers and
  // latch cycles; bounded so a stuck design still reaches the summary.
  task automatic run_frame(output int ncyc, output int nx, output int nl, output bit seen);
    ncyc = 0;
    nx   = 0;
    nl   = 0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (busy) ncyc++;
      if (pix_valid && pix_ready) nx++;
      if (latching) nl++;
      if (frame_done) seen = 1'b1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ncyc, nx, nl, cnt;
    bit          seen, found;
    logic [71:0] face0_lit;

    reset       = 1'b1;
    start       = 1'b0;
    pix_ready   = 1'b1;
    orientation = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_busy", 72'(busy), 72'(0));
      chk("reset_valid", 72'(pix_valid), 72'(0));
    end
    reset = 1'b0;

    // Idle stability: nothing moves without a request.
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || pix_valid || frame_done) cnt++;
    end
    chk("idle_activity", 72'(cnt), 72'(0));
    $display("txn idle: 100 cycles, %0d active cycles", cnt);

    // Basic frame with pix_ready held high.
    for (int i = 0; i < 27; i++) orientation[i*16 +: 16] = 16'($urandom);
    pulse_start();
    run_frame(ncyc, nx, nl, seen);
    chk("basic_done", 72'(seen), 72'(1));
    chk("basic_cycles", 72'(ncyc), 72'(393));
    chk("basic_xfers", 72'(nx), 72'(384));
    chk("basic_latch", 72'(nl), 72'(8));
    $display("txn basic: cycles=%0d xfers=%0d latch=%0d", ncyc, nx, nl);

    // Snapshot integrity, then backpressure at face 2 pixel 63.
    orientation        = '1;
    orientation[71:0]  = {9{8'h01}};
    face0_lit          = 72'h010101010101010101;
    pulse_start();
    @(posedge clk);
    #1 orientation = '1;
    repeat (3) begin
      @(negedge clk);
      chk("snap_face_idx", 72'(face_idx), 72'(0));
      chk("snap_face0", face_orient, face0_lit);
    end
    $display("txn snapshot: face0=%h", face_orient);

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (pix_valid && face_idx == 3'd2 && pix_idx == 6'd63) found = 1'b1;
    end
    chk("bp_reached", 72'(found), 72'(1));
    pix_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_face", 72'(face_idx), 72'(2));
      chk("bp_hold_pix", 72'(pix_idx), 72'(63));
      chk("bp_hold_valid", 72'(pix_valid), 72'(1));
    end
    pix_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_face", 72'(face_idx), 72'(3));
    chk("bp_next_pix", 72'(pix_idx), 72'(0));
    $display("txn backpressure: resumed at (%0d,%0d)", face_idx, pix_idx);
    run_frame(ncyc, nx, nl, seen);
    chk("bp_done", 72'(seen), 72'(1));

    // Pending: three starts during SEND plus one in the frame_done cycle.
    pulse_start();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
    end
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    chk("pend_first_done", 72'(found), 72'(1));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("pend_gap_idle", 72'(busy), 72'(0));
    @(negedge clk);
    chk("pend_snap_busy", 72'(busy), 72'(1));
    run_frame(ncyc, nx, nl, seen);
    chk("pend_second_done", 72'(seen), 72'(1));
    chk("pend_second_cycles", 72'(ncyc), 72'(392));
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("pend_no_third", 72'(cnt), 72'(0));
    $display("txn pending: extra frame cycles=%0d, later busy=%0d", ncyc + 1, cnt);

    // Reset at latch count 4, with start raised alongside it.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (latching) found = 1'b1;
    end
    chk("rst_latch_reached", 72'(found), 72'(1));
    repeat (4) @(negedge clk);
    chk("rst_latch_at4", 72'(latching), 72'(1));
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_latching", 72'(latching), 72'(0));
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done || busy) cnt++;
    end
    chk("rst_no_done", 72'(cnt), 72'(0));
    $display("txn reset_mid_latch: busy=%0d later_activity=%0d", busy, cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
